// File: rtl/clock_pkg.sv
// Shared constants for the clock display path: segment codes, digit slots, field limits.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package clock_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [2:0] DIG_SEC_1   = 3'd0;
  localparam logic [2:0] DIG_SEC_10  = 3'd1;
  localparam logic [2:0] DIG_MIN_1   = 3'd2;
  localparam logic [2:0] DIG_MIN_10  = 3'd3;
  localparam logic [2:0] DIG_HOUR_1  = 3'd4;
  localparam logic [2:0] DIG_HOUR_10 = 3'd5;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  // Decimal digit to segment pattern; anything above 9 shows a dash.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/clock_bin2seg.sv
// Combinational binary-to-two-digit segment converter for one time field.
// Values above P_LIMIT show a dash on both digits.
module clock_bin2seg
  import clock_pkg::*;
#(
  parameter int P_W     = 6,
  parameter int P_LIMIT = 59
) (
  input  logic [P_W-1:0] val,
  output logic [6:0]     tens_seg,
  output logic [6:0]     ones_seg
);

  logic [6:0] val_s;
  logic [3:0] tens_s;
  logic [3:0] ones_s;

  // Split into tens/ones and map each digit, overriding with dashes when out of range.
  always_comb begin
    val_s  = 7'(val);
    tens_s = 4'(val_s / 7'd10);
    ones_s = 4'(val_s % 7'd10);
    if (32'(val) > P_LIMIT) begin
      tens_seg = SEG_DASH;
      ones_seg = SEG_DASH;
    end else begin
      tens_seg = seg_digit(tens_s);
      ones_seg = seg_digit(ones_s);
    end
  end

endmodule

// File: rtl/clock_disp_scan.sv
// Six-digit multiplexed HH.MM.SS display driver with a per-frame time snapshot.
// Optional: define CLOCK_DISP_LZB_EN to blank the hour tens digit when the hour is below 10.
module clock_disp_scan
  import clock_pkg::*;
#(
  parameter int P_SEC_BIT  = 6,
  parameter int P_MIN_BIT  = 6,
  parameter int P_HOUR_BIT = 5,
  parameter int P_SCAN_BIT = 17,
  parameter int P_SCAN_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [P_SEC_BIT-1:0]  sec,
  input  logic [P_MIN_BIT-1:0]  min,
  input  logic [P_HOUR_BIT-1:0] hour,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [5:0]            an_n
);

  localparam logic [P_SCAN_BIT-1:0] LAST_CNT = P_SCAN_BIT'(P_SCAN_DIV - 1);

  logic [P_SCAN_BIT-1:0] cnt_r;
  logic [2:0]            idx_r;
  logic [P_SEC_BIT-1:0]  snap_sec_r;
  logic [P_MIN_BIT-1:0]  snap_min_r;
  logic [P_HOUR_BIT-1:0] snap_hour_r;
  logic                  snap_vld_r;

  logic       slot_end_s;
  logic       frame_end_s;
  logic [6:0] sec_10_s, sec_1_s, min_10_s, min_1_s, hour_10_s, hour_1_s;
  logic [6:0] hour_10_disp_s;
  logic [6:0] seg_sel_s;
  logic       dp_sel_s;

  clock_bin2seg #(.P_W(P_SEC_BIT), .P_LIMIT(SEC_MAX)) u_sec (
    .val(snap_sec_r), .tens_seg(sec_10_s), .ones_seg(sec_1_s)
  );
  clock_bin2seg #(.P_W(P_MIN_BIT), .P_LIMIT(MIN_MAX)) u_min (
    .val(snap_min_r), .tens_seg(min_10_s), .ones_seg(min_1_s)
  );
  clock_bin2seg #(.P_W(P_HOUR_BIT), .P_LIMIT(HOUR_MAX)) u_hour (
    .val(snap_hour_r), .tens_seg(hour_10_s), .ones_seg(hour_1_s)
  );

  // Slot and frame boundaries of the scan prescaler.
  always_comb begin
    slot_end_s  = (cnt_r == LAST_CNT);
    frame_end_s = slot_end_s && (idx_r == DIG_HOUR_10);
  end

  // Hour tens digit, optionally blanked for hours 0..9 while its anode is still driven.
  always_comb begin
`ifdef CLOCK_DISP_LZB_EN
    if (32'(snap_hour_r) < 32'd10) begin
      hour_10_disp_s = SEG_OFF;
    end else begin
      hour_10_disp_s = hour_10_s;
    end
`else
    hour_10_disp_s = hour_10_s;
`endif
  end

  // Segment and separator selection for the digit currently being scanned.
  always_comb begin
    seg_sel_s = SEG_OFF;
    dp_sel_s  = 1'b1;
    case (idx_r)
      DIG_SEC_1:   seg_sel_s = sec_1_s;
      DIG_SEC_10:  seg_sel_s = sec_10_s;
      DIG_MIN_1:   begin seg_sel_s = min_1_s;  dp_sel_s = 1'b0; end
      DIG_MIN_10:  seg_sel_s = min_10_s;
      DIG_HOUR_1:  begin seg_sel_s = hour_1_s; dp_sel_s = 1'b0; end
      DIG_HOUR_10: seg_sel_s = hour_10_disp_s;
      default:     begin seg_sel_s = SEG_OFF;  dp_sel_s = 1'b1; end
    endcase
  end

  // Scan prescaler, digit index and snapshot; everything holds while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r       <= {P_SCAN_BIT{1'b0}};
      idx_r       <= DIG_SEC_1;
      snap_sec_r  <= {P_SEC_BIT{1'b0}};
      snap_min_r  <= {P_MIN_BIT{1'b0}};
      snap_hour_r <= {P_HOUR_BIT{1'b0}};
      snap_vld_r  <= 1'b0;
    end else if (en) begin
      if (slot_end_s) begin
        cnt_r <= {P_SCAN_BIT{1'b0}};
        idx_r <= (idx_r == DIG_HOUR_10) ? DIG_SEC_1 : idx_r + 3'd1;
      end else begin
        cnt_r <= cnt_r + P_SCAN_BIT'(1);
      end
      // The first enabled edge after reset takes a snapshot so the display never shows stale data for a frame.
      if (!snap_vld_r || frame_end_s) begin
        snap_sec_r  <= sec;
        snap_min_r  <= min;
        snap_hour_r <= hour;
      end
      snap_vld_r <= 1'b1;
    end
  end

  // Registered pin drivers; blanked whenever the display is disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_n  <= 6'b111111;
      seg_n <= SEG_OFF;
      dp_n  <= 1'b1;
    end else if (en) begin
      an_n  <= ~(6'b000001 << idx_r);
      seg_n <= seg_sel_s;
      dp_n  <= dp_sel_s;
    end else begin
      an_n  <= 6'b111111;
      seg_n <= SEG_OFF;
      dp_n  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clock_disp_scan.sv
// Directed self-checking bench for clock_disp_scan with a 4-clock digit slot.
module tb_clock_disp_scan;
  import clock_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] an_n;

  int checks = 0;
  int errors = 0;

`ifdef CLOCK_DISP_LZB_EN
  localparam logic [6:0] EXP_H10_5 = 7'h7F;
`else
  localparam logic [6:0] EXP_H10_5 = 7'h40;
`endif

  clock_disp_scan #(
    .P_SEC_BIT(6), .P_MIN_BIT(6), .P_HOUR_BIT(5), .P_SCAN_BIT(17), .P_SCAN_DIV(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .sec(sec), .min(min), .hour(hour),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, leaving time at the following falling edge for sampling.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; sec = 6'd12; min = 6'd34; hour = 5'd5;
    tick(2);
    checks++;
    if ({an_n, seg_n, dp_n} !== {6'b111111, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL reset: an_n=%b seg_n=%h dp_n=%b expected 111111 7f 1", an_n, seg_n, dp_n);
    end
  endtask

  task automatic test_rotation();
    logic [6:0] seg_tab [6];
    logic [5:0] an_exp;
    logic       dp_exp;
    seg_tab[0] = 7'h24; seg_tab[1] = 7'h79; seg_tab[2] = 7'h19;
    seg_tab[3] = 7'h30; seg_tab[4] = 7'h12; seg_tab[5] = EXP_H10_5;
    en = 1'b1;
    reset_n = 1'b1;
    tick(1);
    checks++;
    if (an_n !== 6'b111110) begin
      errors++;
      $display("FAIL first_slot: an_n=%b expected 111110", an_n);
    end
    tick(23);
    for (int k = 0; k < 6; k++) begin
      an_exp = ~(6'b000001 << k);
      dp_exp = (k == 2 || k == 4) ? 1'b0 : 1'b1;
      for (int e = 0; e < 4; e++) begin
        tick(1);
        checks++;
        if ({an_n, seg_n, dp_n} !== {an_exp, seg_tab[k], dp_exp}) begin
          errors++;
          $display("FAIL rotation slot%0d edge%0d: an_n=%b seg_n=%h dp_n=%b expected %b %h %b",
                   k, e, an_n, seg_n, dp_n, an_exp, seg_tab[k], dp_exp);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    tick(8);
    sec = 6'd13;
    tick(16);
    tick(1);
    checks++;
    if ({an_n, seg_n} !== {6'b111110, 7'h30}) begin
      errors++;
      $display("FAIL snap_new_frame: an_n=%b seg_n=%h expected 111110 30", an_n, seg_n);
    end
    sec = 6'd47;
    tick(3);
    checks++;
    if ({an_n, seg_n} !== {6'b111110, 7'h30}) begin
      errors++;
      $display("FAIL snap_hold_ones: an_n=%b seg_n=%h expected 111110 30", an_n, seg_n);
    end
    tick(1);
    checks++;
    if ({an_n, seg_n} !== {6'b111101, 7'h79}) begin
      errors++;
      $display("FAIL snap_hold_tens: an_n=%b seg_n=%h expected 111101 79", an_n, seg_n);
    end
    tick(4);
    checks++;
    if ({an_n, seg_n, dp_n} !== {6'b111011, 7'h19, 1'b0}) begin
      errors++;
      $display("FAIL snap_min_ones: an_n=%b seg_n=%h dp_n=%b expected 111011 19 0", an_n, seg_n, dp_n);
    end
  endtask

  task automatic test_enable_gating();
    tick(3);
    tick(1);
    checks++;
    if ({an_n, seg_n, dp_n} !== {6'b110111, 7'h30, 1'b1}) begin
      errors++;
      $display("FAIL gate_before: an_n=%b seg_n=%h dp_n=%b expected 110111 30 1", an_n, seg_n, dp_n);
    end
    en = 1'b0;
    tick(1);
    checks++;
    if ({an_n, seg_n, dp_n} !== {6'b111111, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL gate_blank: an_n=%b seg_n=%h dp_n=%b expected 111111 7f 1", an_n, seg_n, dp_n);
    end
    tick(9);
    checks++;
    if ({an_n, seg_n, dp_n} !== {6'b111111, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL gate_hold_blank: an_n=%b seg_n=%h dp_n=%b expected 111111 7f 1", an_n, seg_n, dp_n);
    end
    en = 1'b1;
    tick(3);
    checks++;
    if ({an_n, seg_n} !== {6'b110111, 7'h30}) begin
      errors++;
      $display("FAIL gate_resume: an_n=%b seg_n=%h expected 110111 30", an_n, seg_n);
    end
    tick(1);
    checks++;
    if ({an_n, dp_n} !== {6'b101111, 1'b0}) begin
      errors++;
      $display("FAIL gate_held_cnt: an_n=%b dp_n=%b expected 101111 0", an_n, dp_n);
    end
  endtask

  task automatic test_out_of_range();
    logic [6:0] seg_tab [6];
    seg_tab[0] = 7'h78; seg_tab[1] = 7'h19; seg_tab[2] = 7'h19;
    seg_tab[3] = 7'h30; seg_tab[4] = 7'h3F; seg_tab[5] = 7'h3F;
    hour = 5'd25;
    tick(3);
    tick(1);
    checks++;
    if ({an_n, seg_n} !== {6'b011111, EXP_H10_5}) begin
      errors++;
      $display("FAIL oor_prev_frame: an_n=%b seg_n=%h expected 011111 %h", an_n, seg_n, EXP_H10_5);
    end
    tick(3);
    for (int k = 0; k < 6; k++) begin
      tick((k == 0) ? 1 : 4);
      checks++;
      if ({an_n, seg_n} !== {~(6'b000001 << k), seg_tab[k]}) begin
        errors++;
        $display("FAIL oor slot%0d: an_n=%b seg_n=%h expected %b %h",
                 k, an_n, seg_n, ~(6'b000001 << k), seg_tab[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    hour = 5'd5;
    tick(3);
    tick(17);
    checks++;
    if ({an_n, seg_n} !== {6'b101111, 7'h12}) begin
      errors++;
      $display("FAIL areset_before: an_n=%b seg_n=%h expected 101111 12", an_n, seg_n);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({an_n, seg_n, dp_n} !== {6'b111111, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL areset_blank: an_n=%b seg_n=%h dp_n=%b expected 111111 7f 1", an_n, seg_n, dp_n);
    end
    tick(2);
    reset_n = 1'b1;
    tick(1);
    checks++;
    if (an_n !== 6'b111110) begin
      errors++;
      $display("FAIL areset_restart: an_n=%b expected 111110", an_n);
    end
    tick(1);
    checks++;
    if ({an_n, seg_n} !== {6'b111110, 7'h78}) begin
      errors++;
      $display("FAIL areset_fresh_snap: an_n=%b seg_n=%h expected 111110 78", an_n, seg_n);
    end
  endtask

  task automatic test_lzb();
    tick(19);
    checks++;
    if ({an_n, seg_n, dp_n} !== {6'b011111, EXP_H10_5, 1'b1}) begin
      errors++;
      $display("FAIL lzb: an_n=%b seg_n=%h dp_n=%b expected 011111 %h 1", an_n, seg_n, dp_n, EXP_H10_5);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_snapshot();
    test_enable_gating();
    test_out_of_range();
    test_async_reset();
    test_lzb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
